// File: rtl/alu_spi_pkg.sv
// alu_spi_pkg: shared FSM type, frame sizes and opcodes for the ALU SPI slave.
// Optional build macro used elsewhere: ALU_SPI_STATUS_EN.
package alu_spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_ISSUE,
      ST_CAPTURE
   } state_t;

   localparam int FRAME_BITS  = 24;
   localparam int RESULT_BITS = 8;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MIX = 3'b111;

endpackage

// File: rtl/alu_spi_slave_edge_sync.sv
// spi_edge_sync: synchronizers for sclk/cs_n/mosi plus edge pulses.
// The cs_n chain resets low so a cs_n held low through reset never looks like a fall.
module spi_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk,
   input  logic cs_n,
   input  logic mosi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_fall,
   output logic cs_rise,
   output logic cs_low,
   output logic mosi_s
);

   logic [SYNC_STAGES-1:0] sclk_q;
   logic [SYNC_STAGES-1:0] cs_q;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic                   sclk_d;
   logic                   cs_d;
   logic                   armed;

   // synchronizer chains, one-cycle delayed copies, and cs_n-seen-high flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q <= '0;
         cs_q   <= '0;
         mosi_q <= '0;
         sclk_d <= 1'b0;
         cs_d   <= 1'b0;
         armed  <= 1'b0;
      end else begin
         sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
         cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
         mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
         sclk_d <= sclk_q[SYNC_STAGES-1];
         cs_d   <= cs_q[SYNC_STAGES-1];
         armed  <= armed | cs_q[SYNC_STAGES-1];
      end
   end

   assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_d;
   assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_d;
   assign cs_fall   = ~cs_q[SYNC_STAGES-1] & cs_d;
   assign cs_rise   = cs_q[SYNC_STAGES-1] & ~cs_d;
   assign cs_low    = armed & ~cs_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/alu_spi_slave.sv
// alu_spi_slave: SPI mode-0 slave that loads ALU operands and returns the result.
// Define ALU_SPI_STATUS_EN to return a status byte in MISO bits 8-15.
module alu_spi_slave
   import alu_spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sclk,
   input  logic                   cs_n,
   input  logic                   mosi,
   output logic                   miso,
   output logic                   miso_oe,
   output logic [7:0]             alu_a,
   output logic [7:0]             alu_b,
   output logic [2:0]             alu_sel,
   output logic                   aluop_st,
   input  logic [RESULT_BITS-1:0] alu_out,
   output logic                   busy,
   output logic                   frame_err
);

   localparam int         CNT_W    = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

   logic sclk_rise;
   logic sclk_fall;
   logic cs_fall;
   logic cs_rise;
   logic cs_low;
   logic mosi_s;

   state_t                   state;
   state_t                   next;
   logic [CNT_W-1:0]         cnt;
   logic [FRAME_BITS-6:0]    rx;
   logic [FRAME_BITS-1:0]    tx;
   logic [RESULT_BITS-1:0]   result;
   logic [RESULT_BITS-1:0]   load_res;
   logic [7:0]               stat;
   logic                     pend;
   logic                     start;
   logic                     issue;
   logic                     abort;

   spi_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .sclk     (sclk),
      .cs_n     (cs_n),
      .mosi     (mosi),
      .sclk_rise(sclk_rise),
      .sclk_fall(sclk_fall),
      .cs_fall  (cs_fall),
      .cs_rise  (cs_rise),
      .cs_low   (cs_low),
      .mosi_s   (mosi_s)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next;
   end

   // next-state; a 25th sclk rise aborts the frame at once
   always_comb begin
      next = state;
      unique case (state)
         ST_IDLE: begin
            if (cs_fall) next = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (sclk_rise && cnt == CNT_FULL) next = ST_IDLE;
            else if (cs_rise)
               next = (cnt == CNT_FULL) ? ST_ISSUE : ST_IDLE;
         end
         ST_ISSUE: next = ST_CAPTURE;
         ST_CAPTURE: begin
            if (pend || cs_fall) next = ST_SHIFT;
            else                 next = ST_IDLE;
         end
         default: next = ST_IDLE;
      endcase
   end

   assign start    = (next == ST_SHIFT) && (state != ST_SHIFT);
   assign issue    = (state == ST_SHIFT) && (next == ST_ISSUE);
   assign abort    = (state == ST_SHIFT) && (next == ST_IDLE);
   assign load_res = (state == ST_CAPTURE) ? alu_out : result;
   assign busy     = (state != ST_IDLE);
   assign miso     = tx[FRAME_BITS-1];
   assign miso_oe  = cs_low;

`ifdef ALU_SPI_STATUS_EN
   logic [3:0] op_cnt;

   // wrapping count of issued operations
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     op_cnt <= '0;
      else if (issue) op_cnt <= op_cnt + 4'd1;
   end

   assign stat = {frame_err, 3'b000, op_cnt};
`else
   assign stat = 8'h00;
`endif

   // frame shifting, operand load, strobe, status and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         rx        <= '0;
         tx        <= '0;
         result    <= '0;
         pend      <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         aluop_st  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         aluop_st <= issue;
         if (start) begin
            cnt <= '0;
            tx  <= {load_res, stat, 8'h00};
         end else if (state == ST_SHIFT) begin
            if (sclk_rise && cnt != CNT_FULL) begin
               rx  <= {rx[FRAME_BITS-7:0], mosi_s};
               cnt <= cnt + 1'b1;
            end
            if (sclk_fall) tx <= {tx[FRAME_BITS-2:0], 1'b0};
         end
         if (issue) begin
            alu_sel   <= rx[18:16];
            alu_a     <= rx[15:8];
            alu_b     <= rx[7:0];
            frame_err <= 1'b0;
         end
         if (abort) frame_err <= 1'b1;
         if (state == ST_CAPTURE) result <= alu_out;
         pend <= (state == ST_ISSUE) && (pend || cs_fall);
      end
   end

endmodule

// File: tb/tb_alu_spi_slave.sv
// tb_alu_spi_slave: randomized SPI frames against a frame-level reference model.
// Includes a behavioural ALU; honours ALU_SPI_STATUS_EN for the status byte.
`timescale 1ns/1ps
module tb_alu_spi_slave;

   localparam int HALF = 6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       cs_n = 1'b1;
   logic       mosi = 1'b0;
   logic       miso;
   logic       miso_oe;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [2:0] alu_sel;
   logic       aluop_st;
   logic [7:0] alu_out;
   logic       busy;
   logic       frame_err;

   int checks = 0;
   int failures = 0;
   int strobes = 0;

   logic [7:0] m_result;
   logic [7:0] m_a;
   logic [7:0] m_b;
   logic [2:0] m_sel;
   logic       m_err;
   int         m_ops;

   always #5 clk = ~clk;

   alu_spi_slave #(.SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sclk     (sclk),
      .cs_n     (cs_n),
      .mosi     (mosi),
      .miso     (miso),
      .miso_oe  (miso_oe),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_sel  (alu_sel),
      .aluop_st (aluop_st),
      .alu_out  (alu_out),
      .busy     (busy),
      .frame_err(frame_err)
   );

   function automatic logic [7:0] alu_fn(input logic [2:0] s,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      case (s)
         3'd0: return sum[8:1];
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return a << 1;
         3'd6: return b >> 1;
         default: return {a[3:0], b[3:0]};
      endcase
   endfunction

   // ALU: result registered on the strobe edge, cleared on the next edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)        alu_out <= 8'h00;
      else if (aluop_st) alu_out <= alu_fn(alu_sel, alu_a, alu_b);
      else               alu_out <= 8'h00;
   end

   // strobe counter
   always @(negedge clk) if (aluop_st) strobes++;

   function automatic logic [7:0] exp_status();
`ifdef ALU_SPI_STATUS_EN
      return {m_err, 3'b000, 4'(m_ops)};
`else
      return 8'h00;
`endif
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      m_result = 8'h00;
      m_a = 8'h00;
      m_b = 8'h00;
      m_sel = 3'd0;
      m_err = 1'b0;
      m_ops = 0;
   endtask

   task automatic spi_bit(input logic b, output logic m);
      mosi = b;
      tick(HALF);
      m = miso;
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
   endtask

   task automatic spi_xfer(input int n, input logic [31:0] data,
                           input int gap, output logic [31:0] rec);
      logic m;
      rec = '0;
      cs_n = 1'b0;
      tick(HALF);
      for (int i = n - 1; i >= 0; i--) begin
         spi_bit(data[i], m);
         rec = {rec[30:0], m};
         if (i == n - 1) begin
            checks++;
            if (busy !== 1'b1 || miso_oe !== 1'b1) begin
               failures++;
               $display("FAIL in_frame busy=%b oe=%b want 1/1", busy, miso_oe);
            end
         end
      end
      tick(HALF);
      cs_n = 1'b1;
      tick(gap);
   endtask

   task automatic run_frame(input string tag, input int n,
                            input logic [31:0] data, input int gap,
                            output logic [23:0] got);
      logic [31:0] rec;
      logic [23:0] exp;
      logic [23:0] want;
      int s0;
      bit good;
      exp = {m_result, exp_status(), 8'h00};
      s0 = strobes;
      spi_xfer(n, data, gap, rec);
      if (n >= 24) begin
         got = 24'(rec >> (n - 24));
         want = exp;
      end else begin
         got = rec[23:0];
         want = exp >> (24 - n);
      end
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s miso got=%h want=%h", tag, got, want);
      end
      good = (n == 24);
      if (good) begin
         m_sel = data[18:16];
         m_a = data[15:8];
         m_b = data[7:0];
         m_result = alu_fn(m_sel, m_a, m_b);
         m_err = 1'b0;
         m_ops++;
      end else begin
         m_err = 1'b1;
      end
      if (gap >= 12) begin
         checks++;
         if (strobes - s0 != int'(good)) begin
            failures++;
            $display("FAIL %s strobes got=%0d want=%0d", tag,
                     strobes - s0, int'(good));
         end
         checks++;
         if ({alu_sel, alu_a, alu_b} !== {m_sel, m_a, m_b}) begin
            failures++;
            $display("FAIL %s operands got=%h/%h/%h want=%h/%h/%h", tag,
                     alu_sel, alu_a, alu_b, m_sel, m_a, m_b);
         end
         checks++;
         if (frame_err !== m_err || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s err/busy got=%b/%b want=%b/0", tag,
                     frame_err, busy, m_err);
         end
      end
   endtask

   task automatic test_reset();
      model_reset();
      tick(3);
      checks++;
      if ({miso, miso_oe, alu_a, alu_b, alu_sel, aluop_st, busy,
           frame_err} !== '0) begin
         failures++;
         $display("FAIL reset_hold outputs not zero a=%h b=%h busy=%b",
                  alu_a, alu_b, busy);
      end
      rst_n = 1'b1;
      tick(10);
      checks++;
      if ({miso, miso_oe, alu_a, alu_b, alu_sel, aluop_st, busy,
           frame_err} !== '0) begin
         failures++;
         $display("FAIL reset_release outputs not zero oe=%b busy=%b",
                  miso_oe, busy);
      end
   endtask

   task automatic test_basic();
      logic [23:0] g;
      run_frame("add", 24, {8'h00, 5'b10101, 3'b000, 8'h10, 8'h20}, 20, g);
      run_frame("and", 24, {8'h00, 5'b00000, 3'b010, 8'hF0, 8'h3C}, 20, g);
      checks++;
      if (g[23:16] !== 8'h18) begin
         failures++;
         $display("FAIL add_result got=%h want=18", g[23:16]);
      end
   endtask

   task automatic test_hold();
      int s0;
      s0 = strobes;
      tick(100);
      checks++;
      if (alu_sel !== 3'b010 || alu_a !== 8'hF0 || alu_b !== 8'h3C
          || strobes != s0) begin
         failures++;
         $display("FAIL hold got=%h/%h/%h strobes=%0d want=2/f0/3c/%0d",
                  alu_sel, alu_a, alu_b, strobes, s0);
      end
   endtask

   task automatic test_bad_frames();
      logic [23:0] g;
      run_frame("short16", 16, 32'h0000_ABCD, 20, g);
      checks++;
      if (g[15:8] !== 8'h30) begin
         failures++;
         $display("FAIL and_result got=%h want=30", g[15:8]);
      end
      run_frame("long25", 25, 32'h01FF_FFFF, 20, g);
      run_frame("after_bad", 24, {8'h00, 8'h04, 8'h5A, 8'hA5}, 20, g);
      checks++;
      if (g[23:16] !== 8'h30) begin
         failures++;
         $display("FAIL result_kept got=%h want=30", g[23:16]);
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] g;
      int s0;
      s0 = strobes;
      run_frame("b2b_1", 24, {8'h00, 8'h03, 8'h12, 8'h34}, 4, g);
      run_frame("b2b_2", 24, {8'h00, 8'h01, 8'h50, 8'h20}, 20, g);
      checks++;
      if (g[23:16] !== alu_fn(3'd3, 8'h12, 8'h34) || strobes - s0 != 2) begin
         failures++;
         $display("FAIL b2b result=%h strobes=%0d want=%h/2", g[23:16],
                  strobes - s0, alu_fn(3'd3, 8'h12, 8'h34));
      end
   endtask

   task automatic test_random();
      logic [23:0] g;
      logic [31:0] d;
      int n;
      int r;
      for (int k = 0; k < 12; k++) begin
         r = $urandom_range(0, 4);
         if (r < 3) n = 24;
         else if (r == 3) n = $urandom_range(4, 23);
         else n = 25 + $urandom_range(0, 3);
         d = $urandom;
         run_frame("random", n, d, 20, g);
      end
   endtask

   task automatic test_rst_mid();
      logic m;
      logic [23:0] g;
      int s0;
      cs_n = 1'b0;
      tick(HALF);
      for (int i = 0; i < 12; i++) spi_bit(i[0], m);
      rst_n = 1'b0;
      tick(2);
      checks++;
      if ({miso, miso_oe, alu_a, alu_b, alu_sel, aluop_st, busy,
           frame_err} !== '0) begin
         failures++;
         $display("FAIL rst_mid outputs a=%h b=%h busy=%b oe=%b",
                  alu_a, alu_b, busy, miso_oe);
      end
      model_reset();
      s0 = strobes;
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) spi_bit(1'b1, m);
      checks++;
      if (busy !== 1'b0 || miso_oe !== 1'b0) begin
         failures++;
         $display("FAIL rst_ignore busy=%b oe=%b want 0/0", busy, miso_oe);
      end
      tick(HALF);
      cs_n = 1'b1;
      tick(20);
      checks++;
      if (strobes != s0 || frame_err !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_after strobes=%0d err=%b want %0d/0",
                  strobes, frame_err, s0);
      end
      run_frame("post_rst", 24, {8'h00, 8'h04, 8'h0F, 8'hF5}, 20, g);
      run_frame("post_rst2", 24, {8'h00, 8'h00, 8'h01, 8'h03}, 20, g);
   endtask

   task automatic test_status();
      logic [23:0] g;
      logic [7:0] want;
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      model_reset();
      tick(10);
      for (int k = 0; k < 3; k++)
         run_frame("st_good", 24, $urandom, 20, g);
      run_frame("st_bad", 10, 32'h155, 20, g);
      run_frame("st_read", 24, $urandom, 20, g);
`ifdef ALU_SPI_STATUS_EN
      want = 8'h83;
`else
      want = 8'h00;
`endif
      checks++;
      if (g[15:8] !== want) begin
         failures++;
         $display("FAIL status got=%h want=%h", g[15:8], want);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_bad_frames();
      test_back_to_back();
      test_random();
      test_rst_mid();
      test_status();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_spi_slave.md
# alu_spi_slave

SPI slave front-end for the ALU. It receives a 24-bit command frame (opcode, operand A, operand B) from an external SPI master and drives the ALU operand/select inputs. It issues a one-cycle `aluop_st` strobe, captures the ALU result, and shifts that result back to the master on MISO during the next frame. The block sits between the chip-level SPI pins and the ALU, entirely in the `clk` domain; SPI signals are oversampled.

## Interface
- `SYNC_STAGES`, 2, synchronizer depth for `sclk`, `cs_n` and `mosi` (minimum 2)
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `sclk`  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
- `cs_n`  in  1  SPI chip select, active low
- `mosi`  in  1  serial data in, MSB first
- `miso`  out  1  serial data out, MSB first
- `miso_oe`  out  1  MISO output enable, high while `cs_n` is synchronized-low
- `alu_a`  out  8  ALU operand A
- `alu_b`  out  8  ALU operand B
- `alu_sel`  out  3  ALU operation select
- `aluop_st`  out  1  ALU start strobe, one `clk` cycle
- `alu_out`  in  8  ALU registered result
- `busy`  out  1  high in any state other than IDLE
- `frame_err`  out  1  status of the last completed frame (1 = malformed)

## Operation
- Frame layout, 24 bits: byte0 = `{5'bx, sel[2:0]}`, byte1 = A, byte2 = B. Bits [7:3] of byte0 are ignored.
- FSM states: IDLE, SHIFT, ISSUE, CAPTURE.
  - IDLE → SHIFT on a synchronized `cs_n` fall. The bit counter clears and the result register's MSB goes on `miso`.
  - SHIFT: MOSI is sampled on each detected `sclk` rise into a 24-bit shift register, and the counter increments (saturating at 24). `miso` advances on each detected `sclk` fall.
  - SHIFT → ISSUE on a `cs_n` rise with count == 24. `alu_sel`/`alu_a`/`alu_b` load from the shift register, `aluop_st` = 1 for exactly this cycle, and `frame_err` ← 0.
  - SHIFT → IDLE on a `cs_n` rise with count ≠ 24, or if more than 24 rising edges were seen. The frame is discarded, `frame_err` ← 1, and there is no strobe. ALU outputs and the result register are unchanged.
  - ISSUE → CAPTURE unconditionally. The ALU updates its result on the edge where `aluop_st` is high.
  - In CAPTURE, `alu_out` is latched into the result register (the ALU clears its output on the following edge), then the FSM returns to IDLE.
- MISO content: bits 0–7 of a frame carry the result register. Remaining bits are 0.
- `alu_a`, `alu_b` and `alu_sel` hold between ISSUE events.
- A `cs_n` fall detected in ISSUE or CAPTURE is latched. The FSM then enters SHIFT directly from CAPTURE, and that frame shifts out the freshly captured result.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `alu_a`=0, `alu_b`=0, `alu_sel`=0, `aluop_st`=0, `busy`=0, `frame_err`=0. The result register, shift register and counter are all 0, and the FSM is in IDLE.
- `rst_n` assertion mid-frame aborts immediately. After release, the block waits for a fresh `cs_n` fall; a `cs_n` already low at release is ignored until it goes high.
- Edge-detect latency is SYNC_STAGES+1 `clk` cycles from the pin.
- Required `sclk` high and low times are ≥ SYNC_STAGES+2 `clk` cycles each.
- Latency from synchronized `cs_n` rise to `aluop_st` is 1 cycle. The result is latched 2 cycles after that rise.
- Minimum `cs_n` high time between frames is 4 `clk` cycles.

## Configuration
- `ALU_SPI_STATUS_EN` defined: bits 8–15 of every MISO frame carry the status byte `{frame_err, 3'b0, op_cnt[3:0]}`. `op_cnt` is a wrapping count of issued operations, reset to 0.
- `ALU_SPI_STATUS_EN` undefined: bits 8–23 are 0, and no `op_cnt` logic is present.

## Structure
- Package `alu_spi_pkg` holds:
  - the FSM state enum;
  - `FRAME_BITS`=24 and `RESULT_BITS`=8;
  - the opcode constants `OP_ADD`..`OP_MIX` (3'b000..3'b111).
- Sub-module `spi_edge_sync` holds the SYNC_STAGES synchronizers plus rise/fall pulse generation for `sclk` and `cs_n`, and the synchronized `mosi`.

## Test plan
- sel=000, A=0x10, B=0x20 → single `aluop_st` pulse, `alu_out`=0x18. The next frame's first MISO byte is 0x18 and `frame_err`=0.
- sel=010, A=0xF0, B=0x3C → MISO result 0x30. `alu_a`/`alu_b`/`alu_sel` hold through 100 idle cycles.
- 16-bit frame, then a 25-bit frame → no `aluop_st`, `frame_err`=1 after each. The next MISO result byte is unchanged from the previous good frame.
- Back-to-back good frames with `cs_n` high for 4 cycles → both operations issued, and the second frame returns the first frame's result.
- `rst_n` pulse at bit 12 of a frame → all outputs return to reset values, no strobe. The next clean frame operates normally.
- With `ALU_SPI_STATUS_EN`, after 3 good frames and 1 bad frame → status byte 0x83.
